arb_mux_rr: RTL and testbench



---
 rtl/arb_mux_rr.sv | 152 +++++++++++++++
 tb/tb_arb_mux_rr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_rr.sv
// Purpose: N-way valid/ready channel arbiter (fixed priority, round-robin or external select) feeding one registered output stage.
// Latency: one cycle from input handshake to out_valid; sustains one word per cycle.
// Backpressure: out_ready low with a full stage holds the stage and drops every in_ready; the stage refills in the cycle it drains.
module arb_mux_rr #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 1,
    parameter int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SELW-1:0]         sel_in,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SELW-1:0]         out_sel
);

    // Selection policies.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_EXT   = 2;

    // Highest legal channel index; the round-robin pointer wraps here, not at 2^SELW.
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_IN - 1);

    // Output stage can take a word when empty or being drained this cycle.
    logic                  load_en;

    // Lowest requesting channel overall, and lowest at or above the rr pointer.
    logic                  lo_found;
    logic [SELW-1:0]       lo_idx;
    logic                  hi_found;
    logic [SELW-1:0]       hi_idx;

    // External select decode; only matches a legal, requesting channel.
    logic                  ext_found;

    // Final grant for the active policy.
    logic                  grant_vld;
    logic [SELW-1:0]       grant_idx;
    logic [WIDTH-1:0]      grant_data;

    // A channel is consumed this cycle.
    logic                  xfer;

    // Round-robin pointer: channel with highest priority on the next search.
    logic [SELW-1:0]       rr_ptr;
    logic [SELW-1:0]       rr_next;

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && grant_vld && !reset;

    // Priority scan: iterate downward so the lowest qualifying index is written last.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = SELW'(i);
                if (SELW'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SELW'(i);
                end
            end
        end
    end

    // External select: out-of-range sel_in matches no channel, so it never grants.
    always_comb begin
        ext_found = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_in == SELW'(i)) begin
                ext_found = in_valid[i];
            end
        end
    end

    // Policy select. Round-robin takes the first requester at/after the pointer,
    // falling back to the lowest requester overall, which is the wrapped search.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        case (MODE)
            MODE_RR: begin
                grant_vld = lo_found;
                grant_idx = hi_found ? hi_idx : lo_idx;
            end
            MODE_EXT: begin
                grant_vld = ext_found;
                grant_idx = ext_found ? sel_in : '0;
            end
            default: begin
                grant_vld = lo_found;
                grant_idx = lo_idx;
            end
        endcase
    end

    // Data mux over legal channels only; constant slices keep every select in range.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready to the granted channel; all low under reset or backpressure.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer && grant_idx == SELW'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + SELW'(1);

    // Output stage: load on transfer, empty when loadable with no grant, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_sel  <= grant_idx;
            end
        end
    end

    // Pointer moves past the winner only on a real transfer, and only in round-robin.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (MODE == MODE_RR && xfer) begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
module tb_arb_mux_rr;

    logic clk;
    logic rst;
    logic rst_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // DUT A: round-robin, 4 channels.
    logic [127:0] a_din;
    logic [3:0]   a_iv;
    logic [3:0]   a_ir;
    logic [1:0]   a_sel;
    logic [31:0]  a_odata;
    logic         a_ov;
    logic         a_ordy;
    logic [1:0]   a_osel;

    // DUT B: fixed priority, 4 channels.
    logic [127:0] b_din;
    logic [3:0]   b_iv;
    logic [3:0]   b_ir;
    logic [1:0]   b_sel;
    logic [31:0]  b_odata;
    logic         b_ov;
    logic         b_ordy;
    logic [1:0]   b_osel;

    // DUT C: external select, 3 channels.
    logic [95:0]  c_din;
    logic [2:0]   c_iv;
    logic [2:0]   c_ir;
    logic [1:0]   c_sel;
    logic [31:0]  c_odata;
    logic         c_ov;
    logic         c_ordy;
    logic [1:0]   c_osel;

    arb_mux_rr #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_a (
        .clk(clk), .reset(rst), .in_data(a_din), .in_valid(a_iv), .in_ready(a_ir),
        .sel_in(a_sel), .out_data(a_odata), .out_valid(a_ov), .out_ready(a_ordy), .out_sel(a_osel)
    );

    arb_mux_rr #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_b (
        .clk(clk), .reset(rst), .in_data(b_din), .in_valid(b_iv), .in_ready(b_ir),
        .sel_in(b_sel), .out_data(b_odata), .out_valid(b_ov), .out_ready(b_ordy), .out_sel(b_osel)
    );

    arb_mux_rr #(.WIDTH(32), .NUM_IN(3), .MODE(2)) dut_c (
        .clk(clk), .reset(rst_c), .in_data(c_din), .in_valid(c_iv), .in_ready(c_ir),
        .sel_in(c_sel), .out_data(c_odata), .out_valid(c_ov), .out_ready(c_ordy), .out_sel(c_osel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row: inputs driven after a falling edge, expectations valid before the next rising edge.
    typedef struct {
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [1:0]  osel;
        logic [31:0] odata;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        tests = 0;
        fails = 0;

        // Round-robin table for DUT A; data of channel i is A0+i.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0};   // first grant after reset -> ch0
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'hA0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'hA1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'hA2};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'hA3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'hA0};   // wrapped back to ch0
        tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1, 32'hA1};   // grant ch3
        tbl[7]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 32'hA3};   // after ch3 -> ch0
        tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 32'hA0};   // then ch3
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'hA3};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'hA3};   // empty; data/sel held
        tbl[11] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd3, 32'hA3};   // empty stage loads despite out_ready=0
        tbl[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};   // backpressure
        tbl[13] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
        tbl[14] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hA2};
        tbl[15] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'hA2};   // drain and load together
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'hA3};
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA3};

        // Reset with every channel requesting.
        rst    = 1'b1;
        rst_c  = 1'b1;
        a_din  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        a_iv   = 4'b1111;
        a_ordy = 1'b1;
        a_sel  = 2'd0;
        b_din  = '0;
        b_iv   = 4'b1111;
        b_ordy = 1'b1;
        b_sel  = 2'd0;
        c_din  = {32'hC2, 32'hC1, 32'hC0};
        c_iv   = 3'b111;
        c_ordy = 1'b1;
        c_sel  = 2'd0;

        @(negedge clk);
        @(negedge clk);
        #2;
        check("reset a_in_ready", 32'(a_ir), 32'h0);
        check("reset a_out_valid", 32'(a_ov), 32'h0);
        check("reset a_out_data", a_odata, 32'h0);
        check("reset a_out_sel", 32'(a_osel), 32'h0);
        check("reset b_in_ready", 32'(b_ir), 32'h0);
        check("reset c_in_ready", 32'(c_ir), 32'h0);
        rst   = 1'b0;
        rst_c = 1'b0;
        a_iv  = '0;
        b_iv  = '0;
        c_iv  = '0;

        // Round-robin table.
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            a_iv   = tbl[k].iv;
            a_ordy = tbl[k].ordy;
            #2;
            check($sformatf("rr[%0d] in_ready", k), 32'(a_ir), 32'(tbl[k].ir));
            check($sformatf("rr[%0d] out_valid", k), 32'(a_ov), 32'(tbl[k].ov));
            check($sformatf("rr[%0d] out_sel", k), 32'(a_osel), 32'(tbl[k].osel));
            check($sformatf("rr[%0d] out_data", k), a_odata, tbl[k].odata);
        end
        a_iv = '0;

        // Fixed priority: ch1 wins every cycle, ch2 starves.
        b_din[32 +: 32] = 32'h11;
        b_din[64 +: 32] = 32'h22;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_iv   = 4'b0110;
            b_ordy = 1'b1;
            #2;
            check($sformatf("fp[%0d] in_ready", k), 32'(b_ir), 32'h2);
            check($sformatf("fp[%0d] out_valid", k), 32'(b_ov), (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) begin
                check($sformatf("fp[%0d] out_data", k), b_odata, 32'h11);
                check($sformatf("fp[%0d] out_sel", k), 32'(b_osel), 32'h1);
            end
        end

        // Backpressure: hold 1234 for three cycles, then refill in the drain cycle.
        @(negedge clk);
        b_din[31:0] = 32'h1234;
        b_iv        = 4'b0001;
        #2;
        check("bp load in_ready", 32'(b_ir), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_ordy          = 1'b0;
            b_iv            = 4'b0110;
            b_din[32 +: 32] = 32'h5555;
            #2;
            check($sformatf("bp[%0d] in_ready", k), 32'(b_ir), 32'h0);
            check($sformatf("bp[%0d] out_valid", k), 32'(b_ov), 32'h1);
            check($sformatf("bp[%0d] out_data", k), b_odata, 32'h1234);
            check($sformatf("bp[%0d] out_sel", k), 32'(b_osel), 32'h0);
        end
        @(negedge clk);
        b_ordy = 1'b1;
        #2;
        check("bp release in_ready", 32'(b_ir), 32'h2);
        check("bp release out_data", b_odata, 32'h1234);
        @(negedge clk);
        b_iv = '0;
        #2;
        check("bp next out_valid", 32'(b_ov), 32'h1);
        check("bp next out_data", b_odata, 32'h5555);
        check("bp next out_sel", 32'(b_osel), 32'h1);

        // External select, 3 channels.
        @(negedge clk);
        c_iv  = 3'b111;
        c_sel = 2'd2;
        #2;
        check("ext sel2 in_ready", 32'(c_ir), 32'h4);
        @(negedge clk);
        c_sel = 2'd3;
        #2;
        check("ext sel3 in_ready", 32'(c_ir), 32'h0);
        check("ext sel2 out_data", c_odata, 32'hC2);
        check("ext sel2 out_sel", 32'(c_osel), 32'h2);
        check("ext sel2 out_valid", 32'(c_ov), 32'h1);
        @(negedge clk);
        #2;
        check("ext oor out_valid", 32'(c_ov), 32'h0);
        check("ext oor out_data held", c_odata, 32'hC2);
        check("ext oor in_ready", 32'(c_ir), 32'h0);
        @(negedge clk);
        c_sel = 2'd1;
        #2;
        check("ext sel1 in_ready", 32'(c_ir), 32'h2);

        // Reset asserted while a word sits in the stage.
        @(negedge clk);
        rst_c = 1'b1;
        c_sel = 2'd0;
        #2;
        check("midrst in_ready", 32'(c_ir), 32'h0);
        check("midrst pre out_valid", 32'(c_ov), 32'h1);
        check("midrst pre out_data", c_odata, 32'hC1);
        @(negedge clk);
        #2;
        check("midrst out_valid", 32'(c_ov), 32'h0);
        check("midrst out_data", c_odata, 32'h0);
        check("midrst out_sel", 32'(c_osel), 32'h0);

        // Selected channel not requesting: no grant.
        @(negedge clk);
        rst_c = 1'b0;
        c_iv  = 3'b101;
        c_sel = 2'd1;
        #2;
        check("ext idle sel in_ready", 32'(c_ir), 32'h0);
        @(negedge clk);
        c_sel = 2'd0;
        #2;
        check("ext sel0 in_ready", 32'(c_ir), 32'h1);
        check("ext sel0 pre out_valid", 32'(c_ov), 32'h0);
        @(negedge clk);
        c_iv = '0;
        #2;
        check("ext sel0 out_valid", 32'(c_ov), 32'h1);
        check("ext sel0 out_data", c_odata, 32'hC0);
        check("ext sel0 out_sel", 32'(c_osel), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
